pmem_arbiter: RTL and testbench

- Single-port controller in front of the 16-bit program-memory array. The array has a one-cycle synchronous read.
- Shares the array between three requesters:
  - the image loader, which sends byte-wide writes from the host download stream;
  - data reads for LPM instructions (byte-addressed);
  - CPU instruction fetch (word-addressed).
- Holds the CPU while an image download is in progress.

---
 rtl/pmem_arbiter_if.sv | 45 ++++
 rtl/pmem_arbiter.sv | 123 ++++++++++++
 tb/tb_pmem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
// Signal bundle between the program-memory arbiter and its requesters and memory array.
// Handshake: dl_we is a one-cycle strobe qualified by dl_en; if_req/lpm_req are levels (lpm_req held until lpm_valid); if_valid/lpm_valid are one-cycle pulses.
interface pmem_arbiter_if #(
    parameter int A = 14
);
    logic          dl_en;
    logic          dl_we;
    logic [A:0]    dl_addr;
    logic [7:0]    dl_data;
    logic          cpu_hold;
    logic          if_req;
    logic [A-1:0]  if_addr;
    logic [15:0]   if_data;
    logic          if_valid;
    logic          lpm_req;
    logic [A:0]    lpm_addr;
    logic [7:0]    lpm_data;
    logic          lpm_valid;
    logic [A-1:0]  mem_addr;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;

    modport slave (
        input  dl_en, dl_we, dl_addr, dl_data,
        output cpu_hold,
        input  if_req, if_addr,
        output if_data, if_valid,
        input  lpm_req, lpm_addr,
        output lpm_data, lpm_valid,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output dl_en, dl_we, dl_addr, dl_data,
        input  cpu_hold,
        output if_req, if_addr,
        input  if_data, if_valid,
        output lpm_req, lpm_addr,
        input  lpm_data, lpm_valid,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/pmem_arbiter.sv
// Single-port program-memory arbiter: image download writes, LPM byte reads and
// instruction fetch share one synchronous-read 16-bit array.
module pmem_arbiter #(
    parameter int ADDR_ROM_BUS_WIDTH = 14
) (
    input  logic              clk,
    input  logic              rst,
    pmem_arbiter_if.slave     bus,
    output logic [1:0]        state_o
);
    localparam int A = ADDR_ROM_BUS_WIDTH;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LPM  = 2'd2
    } grant_e;

    state_e       state_q, state_d;
    grant_e       grant_q, grant_d;
    logic         lpm_pend_q, lpm_pend_d;
    logic         lpm_lsb_q, lpm_lsb_d;
    logic [7:0]   low_q, low_d;
    logic [15:0]  if_data_q, if_data_d;
    logic [7:0]   lpm_data_q, lpm_data_d;

    logic [A-1:0] mem_addr;
    logic         mem_we;
    logic         if_valid;
    logic         lpm_valid;
    logic [7:0]   lpm_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            grant_q    <= GNT_NONE;
            lpm_pend_q <= 1'b0;
            lpm_lsb_q  <= 1'b0;
            low_q      <= 8'h00;
            if_data_q  <= 16'h0000;
            lpm_data_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            lpm_pend_q <= lpm_pend_d;
            lpm_lsb_q  <= lpm_lsb_d;
            low_q      <= low_d;
            if_data_q  <= if_data_d;
            lpm_data_q <= lpm_data_d;
        end
    end

    assign if_valid  = (grant_q == GNT_IF);
    assign lpm_valid = (grant_q == GNT_LPM);
    assign lpm_byte  = lpm_lsb_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0];

    always_comb begin
        state_d    = state_q;
        grant_d    = GNT_NONE;
        lpm_pend_d = 1'b0;
        lpm_lsb_d  = lpm_lsb_q;
        low_d      = low_q;
        if_data_d  = if_valid ? bus.mem_rdata : if_data_q;
        lpm_data_d = lpm_valid ? lpm_byte : lpm_data_q;
        mem_addr   = bus.if_addr;
        mem_we     = 1'b0;

        case (state_q)
            ST_RUN: begin
                // The pending flag keeps a still-high lpm_req from being granted
                // again while its response is on the bus; fetch takes that slot.
                if (bus.lpm_req && !lpm_pend_q) begin
                    grant_d    = GNT_LPM;
                    lpm_pend_d = 1'b1;
                    lpm_lsb_d  = bus.lpm_addr[0];
                    mem_addr   = bus.lpm_addr[A:1];
                end else if (bus.if_req) begin
                    grant_d  = GNT_IF;
                    mem_addr = bus.if_addr;
                end
                if (bus.dl_en) begin
                    state_d    = ST_LOAD;
                    lpm_pend_d = 1'b0;
                end
            end
            ST_LOAD: begin
                mem_addr = bus.dl_addr[A:1];
                if (bus.dl_en && bus.dl_we) begin
                    if (bus.dl_addr[0]) begin
                        mem_we = 1'b1;
                    end else begin
                        low_d = bus.dl_data;
                    end
                end
                if (!bus.dl_en) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = bus.dl_en ? ST_LOAD : ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign bus.cpu_hold  = (state_q != ST_RUN);
    assign bus.if_valid  = if_valid;
    assign bus.if_data   = if_valid ? bus.mem_rdata : if_data_q;
    assign bus.lpm_valid = lpm_valid;
    assign bus.lpm_data  = lpm_valid ? lpm_byte : lpm_data_q;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_we    = mem_we;
    assign bus.mem_wdata = {bus.dl_data, low_q};
    assign state_o       = state_q;
endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter with a synchronous-read program-memory model.
module tb_pmem_arbiter;
    localparam int A = 14;

    logic        clk;
    logic        rst;
    logic [1:0]  state_o;
    int          total;
    int          bad;
    logic [15:0] pm [0:(1<<A)-1];

    pmem_arbiter_if #(.A(A)) bus ();

    pmem_arbiter #(.ADDR_ROM_BUS_WIDTH(A)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.mem_we) pm[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= pm[bus.mem_addr];
    end

    task automatic test_reset;
        @(negedge clk); #1;
        total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL rst_hold got=%b exp=0", bus.cpu_hold); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got=%b exp=0", bus.if_valid); end
        total++; if (bus.lpm_valid !== 1'b0) begin bad++; $display("FAIL rst_lpm_valid got=%b exp=0", bus.lpm_valid); end
        total++; if (bus.if_data !== 16'h0000) begin bad++; $display("FAIL rst_if_data got=%h exp=0000", bus.if_data); end
        total++; if (bus.lpm_data !== 8'h00) begin bad++; $display("FAIL rst_lpm_data got=%h exp=00", bus.lpm_data); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", bus.mem_we); end
        total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_o); end
        rst = 1'b0;
    endtask

    task automatic test_fetch;
        logic [15:0] exp_w [0:2];
        exp_w[0] = 16'h940C; exp_w[1] = 16'h0034; exp_w[2] = 16'h2411;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.if_req  = (i < 3);
            bus.if_addr = 14'(i);
            #1;
            if (i == 0) begin
                total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL fetch_first_valid got=%b exp=0", bus.if_valid); end
            end else begin
                total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL fetch_valid c%0d got=%b exp=1", i, bus.if_valid); end
                total++; if (bus.if_data !== exp_w[i-1]) begin bad++; $display("FAIL fetch_data c%0d got=%h exp=%h", i, bus.if_data, exp_w[i-1]); end
            end
        end
        @(negedge clk); #1;
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL fetch_end_valid got=%b exp=0", bus.if_valid); end
        total++; if (bus.if_data !== 16'h2411) begin bad++; $display("FAIL fetch_hold_data got=%h exp=2411", bus.if_data); end
    endtask

    task automatic test_lpm(input logic [A:0] addr, input logic [7:0] exp_b);
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 14'd5;
        bus.lpm_req = 1'b1; bus.lpm_addr = addr;
        #1;
        total++; if (bus.mem_addr !== 14'h0010) begin bad++; $display("FAIL lpm_prio_addr got=%h exp=0010", bus.mem_addr); end
        total++; if (bus.lpm_valid !== 1'b0) begin bad++; $display("FAIL lpm_early_valid got=%b exp=0", bus.lpm_valid); end
        @(negedge clk); #1;
        total++; if (bus.lpm_valid !== 1'b1) begin bad++; $display("FAIL lpm_valid got=%b exp=1", bus.lpm_valid); end
        total++; if (bus.lpm_data !== exp_b) begin bad++; $display("FAIL lpm_data got=%h exp=%h", bus.lpm_data, exp_b); end
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL lpm_if_stall got=%b exp=0", bus.if_valid); end
        total++; if (bus.mem_addr !== 14'd5) begin bad++; $display("FAIL lpm_pend_addr got=%h exp=0005", bus.mem_addr); end
        @(negedge clk);
        bus.lpm_req = 1'b0;
        #1;
        total++; if (bus.lpm_valid !== 1'b0) begin bad++; $display("FAIL lpm_regrant got=%b exp=0", bus.lpm_valid); end
        total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL lpm_fetch_resume got=%b exp=1", bus.if_valid); end
        total++; if (bus.if_data !== 16'h1234) begin bad++; $display("FAIL lpm_fetch_data got=%h exp=1234", bus.if_data); end
        @(negedge clk);
        bus.if_req = 1'b0;
        #1;
        total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL lpm_fetch_b2b got=%b exp=1", bus.if_valid); end
        total++; if (bus.lpm_valid !== 1'b0) begin bad++; $display("FAIL lpm_once got=%b exp=0", bus.lpm_valid); end
        @(negedge clk); #1;
        total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL lpm_if_idle got=%b exp=0", bus.if_valid); end
        total++; if (bus.lpm_data !== exp_b) begin bad++; $display("FAIL lpm_hold_data got=%h exp=%h", bus.lpm_data, exp_b); end
    endtask

    task automatic test_download;
        logic [7:0] b [0:3];
        b[0] = 8'h0C; b[1] = 8'h94; b[2] = 8'h34; b[3] = 8'h00;
        pm[0] = 16'h0000; pm[1] = 16'h0000;
        @(negedge clk);
        bus.dl_en = 1'b1;
        #1;
        total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL dl_entry_hold got=%b exp=0", bus.cpu_hold); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.dl_we = 1'b1; bus.dl_addr = 15'(i); bus.dl_data = b[i];
            #1;
            total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL dl_hold c%0d got=%b exp=1", i, bus.cpu_hold); end
            total++; if (bus.mem_we !== (i % 2 == 1)) begin bad++; $display("FAIL dl_we c%0d got=%b exp=%b", i, bus.mem_we, (i % 2 == 1)); end
            if (i == 1) begin
                total++; if (bus.mem_addr !== 14'd0 || bus.mem_wdata !== 16'h940C) begin bad++; $display("FAIL dl_word0 got=%h/%h exp=0000/940c", bus.mem_addr, bus.mem_wdata); end
            end
            if (i == 3) begin
                total++; if (bus.mem_addr !== 14'd1 || bus.mem_wdata !== 16'h0034) begin bad++; $display("FAIL dl_word1 got=%h/%h exp=0001/0034", bus.mem_addr, bus.mem_wdata); end
            end
        end
        @(negedge clk);
        bus.dl_we = 1'b0;
        #1;
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL dl_idle_we got=%b exp=0", bus.mem_we); end
        @(negedge clk);
        bus.dl_en = 1'b0;
        #1;
        total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL dl_fall_hold got=%b exp=1", bus.cpu_hold); end
        @(negedge clk); #1;
        total++; if (bus.cpu_hold !== 1'b1 || state_o !== 2'd2) begin bad++; $display("FAIL dl_flush got=%b/%0d exp=1/2", bus.cpu_hold, state_o); end
        @(negedge clk); #1;
        total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL dl_release got=%b exp=0", bus.cpu_hold); end
        total++; if (pm[0] !== 16'h940C || pm[1] !== 16'h0034) begin bad++; $display("FAIL dl_array got=%h/%h exp=940c/0034", pm[0], pm[1]); end
    endtask

    task automatic test_load_block;
        @(negedge clk);
        bus.dl_en = 1'b1; bus.if_req = 1'b1; bus.if_addr = 14'd1;
        #1;
        total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL lb_entry_hold got=%b exp=0", bus.cpu_hold); end
        @(negedge clk);
        bus.lpm_req = 1'b1; bus.lpm_addr = 15'h0021;
        #1;
        total++; if (bus.if_valid !== 1'b1 || bus.if_data !== 16'h0034) begin bad++; $display("FAIL lb_inflight got=%b/%h exp=1/0034", bus.if_valid, bus.if_data); end
        total++; if (bus.cpu_hold !== 1'b1) begin bad++; $display("FAIL lb_hold got=%b exp=1", bus.cpu_hold); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) bus.dl_en = 1'b0;
            #1;
            total++; if (bus.if_valid !== 1'b0 || bus.lpm_valid !== 1'b0) begin bad++; $display("FAIL lb_blocked c%0d got=%b/%b exp=0/0", i, bus.if_valid, bus.lpm_valid); end
        end
        @(negedge clk); #1;
        total++; if (bus.cpu_hold !== 1'b1 || bus.if_valid !== 1'b0 || bus.lpm_valid !== 1'b0) begin bad++; $display("FAIL lb_flush got=%b/%b/%b exp=1/0/0", bus.cpu_hold, bus.if_valid, bus.lpm_valid); end
        @(negedge clk); #1;
        total++; if (bus.cpu_hold !== 1'b0 || bus.mem_addr !== 14'h0010) begin bad++; $display("FAIL lb_run_grant got=%b/%h exp=0/0010", bus.cpu_hold, bus.mem_addr); end
        @(negedge clk); #1;
        total++; if (bus.lpm_valid !== 1'b1 || bus.lpm_data !== 8'hBE || bus.if_valid !== 1'b0) begin bad++; $display("FAIL lb_lpm_first got=%b/%h/%b exp=1/be/0", bus.lpm_valid, bus.lpm_data, bus.if_valid); end
        @(negedge clk);
        bus.lpm_req = 1'b0;
        #1;
        total++; if (bus.if_valid !== 1'b1 || bus.if_data !== 16'h0034) begin bad++; $display("FAIL lb_fetch_after got=%b/%h exp=1/0034", bus.if_valid, bus.if_data); end
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 14'd0;
        @(negedge clk);
        bus.if_req = 1'b0;
        #1;
        total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL rmr_valid got=%b exp=1", bus.if_valid); end
        rst = 1'b1;
        #1;
        total++; if (bus.if_valid !== 1'b0 || bus.if_data !== 16'h0000) begin bad++; $display("FAIL rmr_suppress got=%b/%h exp=0/0000", bus.if_valid, bus.if_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_download;
        @(negedge clk);
        bus.dl_en = 1'b1;
        @(negedge clk);
        bus.dl_we = 1'b1; bus.dl_addr = 15'd2; bus.dl_data = 8'h55;
        #1;
        total++; if (bus.cpu_hold !== 1'b1 || bus.mem_we !== 1'b0) begin bad++; $display("FAIL rdl_even got=%b/%b exp=1/0", bus.cpu_hold, bus.mem_we); end
        @(negedge clk);
        bus.dl_we = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        total++; if (bus.cpu_hold !== 1'b0 || state_o !== 2'd0) begin bad++; $display("FAIL rdl_async got=%b/%0d exp=0/0", bus.cpu_hold, state_o); end
        bus.dl_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.dl_en = 1'b1;
        @(negedge clk);
        bus.dl_we = 1'b1; bus.dl_addr = 15'd3; bus.dl_data = 8'hAA;
        #1;
        total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 14'd1 || bus.mem_wdata !== 16'hAA00) begin bad++; $display("FAIL rdl_odd got=%b/%h/%h exp=1/0001/aa00", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        @(negedge clk);
        bus.dl_we = 1'b0; bus.dl_en = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        total++; if (bus.cpu_hold !== 1'b0) begin bad++; $display("FAIL rdl_release got=%b exp=0", bus.cpu_hold); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.dl_en = 1'b0; bus.dl_we = 1'b0; bus.dl_addr = '0; bus.dl_data = '0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.lpm_req = 1'b0; bus.lpm_addr = '0;
        pm[0] = 16'h940C; pm[1] = 16'h0034; pm[2] = 16'h2411;
        pm[5] = 16'h1234; pm[16] = 16'hBEEF;

        test_reset;
        test_fetch;
        test_lpm(15'h0021, 8'hBE);
        test_lpm(15'h0020, 8'hEF);
        test_download;
        test_load_block;
        test_reset_mid_read;
        test_reset_download;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
